// File: rtl/param_bit_counter.sv
// Up/down counter with a programmable modulus. At the range ends it either wraps
// (and pulses Carry/Borrow) or saturates (and sets sticky Overflow/Underflow).
module param_bit_counter #(
  parameter int              WIDTH    = 8,
  parameter longint unsigned MODULUS  = (64'd1 << WIDTH),
  parameter int              SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ClearCounter,
  input  logic             LoadCounter,
  input  logic [WIDTH-1:0] LoadValue,
  input  logic             IncCounter,
  input  logic             DecCounter,
  output logic [WIDTH-1:0] Count,
  output logic             Carry,
  output logic             Borrow,
  output logic             Overflow,
  output logic             Underflow,
  output logic             AtMax,
  output logic             AtZero
);

  // The modulus is kept at 64 bits so WIDTH=32 with MODULUS=2**32 is representable.
  localparam logic [63:0]      MOD64   = MODULUS;
  localparam logic [63:0]      MAX64   = MOD64 - 64'd1;
  localparam logic [WIDTH-1:0] MAX_VAL = MAX64[WIDTH-1:0];
  localparam bit               SAT_EN  = (SATURATE != 0);

  logic [WIDTH-1:0] count_q, count_d;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic load_in_range;
  logic do_inc;
  logic do_dec;

  assign load_in_range = ({{(64-WIDTH){1'b0}}, LoadValue} < MOD64);
  assign do_inc        = IncCounter && !DecCounter;
  assign do_dec        = DecCounter && !IncCounter;

  always_comb begin
    count_d     = count_q;
    carry_d     = 1'b0;
    borrow_d    = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (ClearCounter) begin
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else if (LoadCounter) begin
      count_d = load_in_range ? LoadValue : MAX_VAL;
    end else if (do_inc) begin
      if (count_q != MAX_VAL) begin
        count_d = count_q + WIDTH'(1);
      end else if (SAT_EN) begin
        overflow_d = 1'b1;
      end else begin
        count_d = '0;
        carry_d = 1'b1;
      end
    end else if (do_dec) begin
      if (count_q != '0) begin
        count_d = count_q - WIDTH'(1);
      end else if (SAT_EN) begin
        underflow_d = 1'b1;
      end else begin
        count_d  = MAX_VAL;
        borrow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= '0;
      carry_q     <= 1'b0;
      borrow_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      carry_q     <= carry_d;
      borrow_q    <= borrow_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign Count     = count_q;
  assign Carry     = carry_q;
  assign Borrow    = borrow_q;
  assign Overflow  = overflow_q;
  assign Underflow = underflow_q;
  assign AtMax     = (count_q == MAX_VAL);
  assign AtZero    = (count_q == '0);

endmodule
